conv_ff_reg: RTL and testbench
==============================

// Module: conv_ff_reg
// PURPOSE
//  WIDTH-bit register in which every bit is a toggle (T) flip-flop core.
//  A per-cycle mode select emulates D, T, JK or SR flip-flop behaviour by
//  converting the inputs into a toggle mask.
//  Also reports which bits toggled, keeps a saturating toggle counter, and
//  holds a sticky SR illegal-input error flag.
//  Used as the generalised flip-flop-conversion block in sequential designs
//  and as a stimulus/observation target for flip-flop conversion exercises.
// PARAMETERS
//  WIDTH      4      number of flip-flop bits (>=1)
//  CNT_W      8      width of toggle counter (>=1)
//  RESET_VAL  0      value loaded into q on reset (WIDTH bits)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  en         in   1      1 = update register this cycle; 0 = hold everything except clears
//  mode       in   2      00 D, 01 T, 10 JK, 11 SR
//  a          in   WIDTH  D: d; T: t; JK: j; SR: s
//  b          in   WIDTH  JK: k; SR: r; ignored in D/T
//  clr_cnt    in   1      clear toggle counter
//  clr_err    in   1      clear sticky SR error
//  q          out  WIDTH  register state
//  t_mask     out  WIDTH  bits toggled on the last update (registered)
//  toggle_cnt out  CNT_W  saturating count of total bit toggles
//  sr_err     out  1      sticky: some bit saw s=r=1 in SR mode
// BEHAVIOUR
//  Reset:
//  - reset=1 at posedge: q=RESET_VAL, t_mask=0, toggle_cnt=0, sr_err=0.
//  - Reset overrides en, the clears and all other inputs.
//  Toggle mask, per bit i (combinational, current q):
//  - D:  t = a ^ q
//  - T:  t = a
//  - JK: t = (a & ~q) | (b & q)      (j=k=1 toggles)
//  - SR: t = (a & ~b & ~q) | (b & ~a & q)
//    - s=r=1 is illegal: t=0 for that bit, so it holds.
//  Update when en=1:
//  - q <= q ^ t; t_mask <= t (one-cycle latency, same edge as q).
//  - toggle_cnt <= min(toggle_cnt + popcount(t), 2^CNT_W-1); saturates, never wraps.
//  - SR mode with any bit a&b=1 -> sr_err <= 1.
//  Hold when en=0:
//  - q holds, t_mask <= 0, count unchanged, no error detection.
//  Clears:
//  - clr_cnt=1: counter <= (en ? popcount(t) : 0).
//    Clear happens first, then the current cycle's toggles are added.
//  - clr_err=1 with a new illegal condition in the same cycle: set wins, sr_err=1.
//  - clr_err=1 otherwise: sr_err <= 0.
//  Mode timing:
//  - mode is sampled every cycle; a change takes effect on that same edge.
//  - No pipeline and no state carried between modes other than q.
//  Arithmetic:
//  - popcount is sized to $clog2(WIDTH+1).
//  - Sum is formed at CNT_W+1 bits before the saturation compare.
//  - If CNT_W is too small to hold popcount(t), the counter still saturates.
// TESTING (WIDTH=4, CNT_W=4, RESET_VAL=0)
//  1. reset; D mode, en=1, a=1010 -> q=1010, t_mask=1010, cnt=2;
//     a=1010 again -> t_mask=0000, cnt=2.
//  2. T mode, a=1111 for 4 cycles from q=0000 -> q=1111,0000,1111,0000; cnt saturates at 15.
//  3. JK, q=0101: j=1111,k=1111 -> q=1010; then j=0000,k=1111 -> q=0000;
//     then j=0011,k=0000 -> q=0011.
//  4. SR, q=0000, s=0011,r=0001 -> q=0010 and sr_err=1;
//     clr_err alone next cycle -> sr_err=0; clr_err with s=r=0001 -> sr_err stays 1.
//  5. en=0 with D a=1111 -> q holds, t_mask=0000, cnt unchanged;
//     clr_cnt=1, en=1, T a=0110 -> cnt=2.
//  6. reset asserted mid-run (q=1011, cnt=9, sr_err=1) -> next edge:
//     q=0000, t_mask=0, cnt=0, sr_err=0.

Source files
------------

// File: rtl/conv_ff_reg.sv
// Register of toggle flip-flops whose per-cycle mode turns D/T/JK/SR inputs into a toggle mask.
// Also records the last toggle mask, a saturating toggle counter and a sticky SR illegal-input flag.
module conv_ff_reg #(
    parameter int                 WIDTH     = 4,
    parameter int                 CNT_W     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              clr_cnt,
    input  logic              clr_err,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  t_mask,
    output logic [CNT_W-1:0]  toggle_cnt,
    output logic              sr_err
);

    localparam int POP_W = $clog2(WIDTH + 1);
    // Sum is wide enough for both the counter and a popcount larger than the counter can hold.
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] t_mask_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;

    logic [WIDTH-1:0] t_next;
    logic [POP_W-1:0] pop_next;
    logic [SUM_W-1:0] sum_next;
    logic [CNT_W-1:0] cnt_next;
    logic             illegal_next;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_comb begin
                t_next[gi] = 1'b0;
                case (mode)
                    MODE_D:  t_next[gi] = a[gi] ^ q_reg[gi];
                    MODE_T:  t_next[gi] = a[gi];
                    MODE_JK: t_next[gi] = (a[gi] & ~q_reg[gi]) | (b[gi] & q_reg[gi]);
                    MODE_SR: t_next[gi] = (a[gi] & ~b[gi] & ~q_reg[gi]) |
                                          (b[gi] & ~a[gi] & q_reg[gi]);
                    default: t_next[gi] = 1'b0;
                endcase
            end
        end
    endgenerate

    always_comb begin
        pop_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_next = pop_next + POP_W'(t_next[i]);
        end
    end

    // Clear first, then add this cycle's toggles; saturate rather than wrap.
    always_comb begin
        sum_next = (clr_cnt ? '0 : SUM_W'(cnt_reg)) + SUM_W'(pop_next);
        cnt_next = (sum_next > CNT_MAX) ? {CNT_W{1'b1}} : sum_next[CNT_W-1:0];
    end

    assign illegal_next = en && (mode == MODE_SR) && (|(a & b));

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg      <= RESET_VAL;
            t_mask_reg <= '0;
            cnt_reg    <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (en) begin
                q_reg      <= q_reg ^ t_next;
                t_mask_reg <= t_next;
                cnt_reg    <= cnt_next;
            end else begin
                t_mask_reg <= '0;
                if (clr_cnt) begin
                    cnt_reg <= '0;
                end
            end
            // A new illegal input wins over a simultaneous clear.
            if (illegal_next) begin
                err_reg <= 1'b1;
            end else if (clr_err) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign q          = q_reg;
    assign t_mask     = t_mask_reg;
    assign toggle_cnt = cnt_reg;
    assign sr_err     = err_reg;

endmodule

// File: tb/tb_conv_ff_reg.sv
// Directed bench for conv_ff_reg (WIDTH=4, CNT_W=4, RESET_VAL=0) with hand-computed expectations.
module tb_conv_ff_reg;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       clr_cnt;
    logic       clr_err;
    logic [3:0] q;
    logic [3:0] t_mask;
    logic [3:0] toggle_cnt;
    logic       sr_err;

    int checks = 0;
    int errors = 0;

    conv_ff_reg #(
        .WIDTH(4),
        .CNT_W(4),
        .RESET_VAL(4'b0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .mode(mode),
        .a(a),
        .b(b),
        .clr_cnt(clr_cnt),
        .clr_err(clr_err),
        .q(q),
        .t_mask(t_mask),
        .toggle_cnt(toggle_cnt),
        .sr_err(sr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, then sample a little after the active edge.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [3:0] va, input logic [3:0] vb,
                        input logic cc, input logic ce);
        reset = r; en = e; mode = m; a = va; b = vb; clr_cnt = cc; clr_err = ce;
        @(posedge clk);
        #1;
        $display("step rst=%b en=%b mode=%b a=%b b=%b clr_cnt=%b clr_err=%b -> q=%b t_mask=%b cnt=%0d sr_err=%b",
                 r, e, m, va, vb, cc, ce, q, t_mask, toggle_cnt, sr_err);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eq, input logic [3:0] et,
                           input logic [3:0] ec, input logic ee);
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".t_mask"}, 32'(t_mask), 32'(et));
        chk({tag, ".cnt"}, 32'(toggle_cnt), 32'(ec));
        chk({tag, ".sr_err"}, 32'(sr_err), 32'(ee));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 2'b00; a = '0; b = '0; clr_cnt = 1'b0; clr_err = 1'b0;
        @(negedge clk);

        // Reset state
        step(1, 0, 2'b00, 4'b0000, 4'b0000, 0, 0);
        chk_all("reset", 4'b0000, 4'b0000, 4'd0, 1'b0);

        // D mode
        step(0, 1, 2'b00, 4'b1010, 4'b0000, 0, 0);
        chk_all("d1", 4'b1010, 4'b1010, 4'd2, 1'b0);
        step(0, 1, 2'b00, 4'b1010, 4'b1111, 0, 0);
        chk_all("d2", 4'b1010, 4'b0000, 4'd2, 1'b0);

        // T mode with counter saturation
        step(1, 0, 2'b00, 4'b0000, 4'b0000, 0, 0);
        step(0, 1, 2'b01, 4'b1111, 4'b0000, 0, 0);
        chk_all("t1", 4'b1111, 4'b1111, 4'd4, 1'b0);
        step(0, 1, 2'b01, 4'b1111, 4'b0000, 0, 0);
        chk_all("t2", 4'b0000, 4'b1111, 4'd8, 1'b0);
        step(0, 1, 2'b01, 4'b1111, 4'b0000, 0, 0);
        chk_all("t3", 4'b1111, 4'b1111, 4'd12, 1'b0);
        step(0, 1, 2'b01, 4'b1111, 4'b0000, 0, 0);
        chk_all("t4_sat", 4'b0000, 4'b1111, 4'd15, 1'b0);
        step(0, 1, 2'b01, 4'b1111, 4'b0000, 0, 0);
        chk_all("t5_sat", 4'b1111, 4'b1111, 4'd15, 1'b0);

        // JK mode from q=0101
        step(0, 1, 2'b00, 4'b0101, 4'b0000, 0, 0);
        chk("jk_pre.q", 32'(q), 32'(4'b0101));
        step(0, 1, 2'b10, 4'b1111, 4'b1111, 0, 0);
        chk("jk_toggle.q", 32'(q), 32'(4'b1010));
        step(0, 1, 2'b10, 4'b0000, 4'b1111, 0, 0);
        chk("jk_reset.q", 32'(q), 32'(4'b0000));
        chk("jk_reset.t_mask", 32'(t_mask), 32'(4'b1010));
        step(0, 1, 2'b10, 4'b0011, 4'b0000, 0, 0);
        chk("jk_set.q", 32'(q), 32'(4'b0011));
        chk("jk_set.t_mask", 32'(t_mask), 32'(4'b0011));

        // SR mode and the sticky error flag
        step(0, 1, 2'b00, 4'b0000, 4'b0000, 0, 0);
        step(0, 1, 2'b11, 4'b0011, 4'b0001, 0, 0);
        chk_all("sr_illegal", 4'b0010, 4'b0010, 4'd15, 1'b1);
        step(0, 0, 2'b11, 4'b0000, 4'b0000, 0, 1);
        chk("sr_clr.sr_err", 32'(sr_err), 32'(1'b0));
        step(0, 0, 2'b11, 4'b1111, 4'b1111, 0, 0);
        chk("sr_en0_nodetect.sr_err", 32'(sr_err), 32'(1'b0));
        step(0, 1, 2'b11, 4'b0001, 4'b0001, 0, 1);
        chk_all("sr_setwins", 4'b0010, 4'b0000, 4'd15, 1'b1);
        step(0, 1, 2'b11, 4'b0000, 4'b0010, 0, 0);
        chk_all("sr_reset_bit", 4'b0000, 4'b0010, 4'd15, 1'b1);
        step(0, 1, 2'b11, 4'b0010, 4'b0000, 0, 0);
        chk("sr_set_bit.q", 32'(q), 32'(4'b0010));

        // Hold and counter clear
        step(0, 0, 2'b00, 4'b1111, 4'b0000, 0, 0);
        chk_all("hold", 4'b0010, 4'b0000, 4'd15, 1'b1);
        step(0, 1, 2'b01, 4'b0110, 4'b0000, 1, 0);
        chk_all("clr_cnt_en", 4'b0100, 4'b0110, 4'd2, 1'b1);
        step(0, 0, 2'b01, 4'b1111, 4'b0000, 1, 0);
        chk_all("clr_cnt_hold", 4'b0100, 4'b0000, 4'd0, 1'b1);

        // Mid-run reset from q=1011, cnt=9, sr_err=1
        step(1, 0, 2'b00, 4'b0000, 4'b0000, 0, 0);
        step(0, 1, 2'b01, 4'b1111, 4'b0000, 0, 0);
        step(0, 1, 2'b01, 4'b0100, 4'b0000, 0, 0);
        step(0, 1, 2'b11, 4'b0001, 4'b0001, 0, 0);
        step(0, 1, 2'b01, 4'b0110, 4'b0000, 0, 0);
        step(0, 1, 2'b01, 4'b0110, 4'b0000, 0, 0);
        chk_all("pre_reset", 4'b1011, 4'b0110, 4'd9, 1'b1);
        step(1, 1, 2'b01, 4'b1111, 4'b0000, 0, 0);
        chk_all("mid_reset", 4'b0000, 4'b0000, 4'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
